// File: rtl/axicb_scfifo_vr_if.sv
// Valid/ready bus of the single-clock crossbar FIFO: write side, read side and fill status.
// The FIFO connects through the slave modport and its user through master.
interface axicb_scfifo_vr_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  i_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic [ADDR_WIDTH:0]   fill;
  logic                  afull;
  logic                  aempty;

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_data, fill, afull, aempty
  );

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_data, fill, afull, aempty
  );
endinterface

// File: rtl/axicb_scfifo_vr.sv
// Single-clock valid/ready FIFO on a 1W/1R register-file RAM, with an optional
// output register stage (FFD_EN) that adds one entry of capacity.
module axicb_scfifo_vr #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FFD_EN        = 0,
  parameter int unsigned AFULL_THRESH  = (2**ADDR_WIDTH) - 1,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             flush,
  axicb_scfifo_vr_if.slave bus
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned CAP   = DEPTH + ((FFD_EN != 0) ? 1 : 0);

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam cnt_t CAP_C    = cnt_t'(CAP);
  localparam cnt_t AFULL_C  = cnt_t'(AFULL_THRESH);
  localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_THRESH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  cnt_t                  cnt_q,    cnt_d;
  logic                  oval_q,   oval_d;
  logic [DATA_WIDTH-1:0] oreg_q,   oreg_d;

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  ram_rd;
  logic                  ram_we;
  logic                  head_valid;
  cnt_t                  fill_w;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign ram_rdata = ram_q[rd_ptr_q];

  // cnt_q counts RAM entries only; the output register adds its valid bit on top.
  always_comb begin
    fill_w     = cnt_q + cnt_t'(oval_q);
    full       = (fill_w == CAP_C);
    push       = bus.i_valid & ~full;
    head_valid = (FFD_EN != 0) ? oval_q : (cnt_q != '0);
    pop        = head_valid & bus.o_ready;
    load       = (FFD_EN != 0) && (cnt_q != '0) && (!oval_q || pop);
    ram_rd     = (FFD_EN != 0) ? load : pop;
    ram_we     = push & ~flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    oval_d   = oval_q;
    oreg_d   = oreg_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      oval_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (ram_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !ram_rd) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (!push && ram_rd) begin
        cnt_d = cnt_q - CNT_ONE;
      end
      // A pop empties the output register unless a refill lands in the same edge.
      if (load) begin
        oval_d = 1'b1;
        oreg_d = ram_rdata;
      end else if (pop && (FFD_EN != 0)) begin
        oval_d = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      oval_q   <= 1'b0;
      oreg_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      oval_q   <= oval_d;
      oreg_q   <= oreg_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (ram_we) begin
      ram_q[wr_ptr_q] <= bus.i_data;
    end
  end

  assign bus.i_ready = ~full;
  assign bus.o_valid = head_valid;
  assign bus.o_data  = (FFD_EN != 0) ? oreg_q : ram_rdata;
  assign bus.fill    = fill_w;
  assign bus.afull   = (fill_w >= AFULL_C);
  assign bus.aempty  = (fill_w <= AEMPTY_C);

endmodule

// File: tb/tb_axicb_scfifo_vr.sv
// Directed bench for axicb_scfifo_vr: one instance without and one with the output
// register stage, both at depth 4, plus a randomised ordering run on each.
module tb_axicb_scfifo_vr;
  logic aclk;
  logic aresetn;
  logic flush0;
  logic flush1;

  int n_assert = 0;
  int n_fail   = 0;

  axicb_scfifo_vr_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) b0 ();
  axicb_scfifo_vr_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) b1 ();

  axicb_scfifo_vr #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FFD_EN(0)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .flush(flush0), .bus(b0)
  );

  axicb_scfifo_vr #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FFD_EN(1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .flush(flush1), .bus(b1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp2 [5];
    int  wr0, rd0, wr1, rd1, cyc;
    logic p0, q0, p1, q1;

    aresetn = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
    b0.i_valid = 1'b0; b0.i_data = '0; b0.o_ready = 1'b0;
    b1.i_valid = 1'b0; b1.i_data = '0; b1.o_ready = 1'b0;

    // reset state
    #2;
    chk("rst0_i_ready", b0.i_ready === 1'b1, b0.i_ready, 1);
    chk("rst0_o_valid", b0.o_valid === 1'b0, b0.o_valid, 0);
    chk("rst0_fill",    b0.fill === 3'd0,    b0.fill,    0);
    chk("rst0_afull",   b0.afull === 1'b0,   b0.afull,   0);
    chk("rst0_aempty",  b0.aempty === 1'b1,  b0.aempty,  1);
    chk("rst1_i_ready", b1.i_ready === 1'b1, b1.i_ready, 1);
    chk("rst1_o_valid", b1.o_valid === 1'b0, b1.o_valid, 0);
    chk("rst1_fill",    b1.fill === 3'd0,    b1.fill,    0);
    #20 aresetn = 1'b1;
    tick();

    // fill to capacity with no reader, refuse a fifth push, drain in order
    for (int i = 0; i < 4; i++) begin
      b0.i_valid = 1'b1; b0.i_data = 8'(8'hA0 + i);
      tick();
      chk("t1_fill_up", 32'(b0.fill) === 32'(i + 1), b0.fill, i + 1);
    end
    chk("t1_full_i_ready", b0.i_ready === 1'b0, b0.i_ready, 0);
    chk("t1_full_afull",   b0.afull === 1'b1,   b0.afull,   1);
    chk("t1_full_aempty",  b0.aempty === 1'b0,  b0.aempty,  0);
    b0.i_data = 8'hEE;
    tick();
    chk("t1_refused_fill", b0.fill === 3'd4, b0.fill, 4);
    b0.i_valid = 1'b0;
    b0.o_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_pop_valid", b0.o_valid === 1'b1, b0.o_valid, 1);
      chk("t1_pop_data",  b0.o_data === 8'(8'hA0 + i), b0.o_data, 8'hA0 + i);
      tick();
    end
    b0.o_ready = 1'b0;
    chk("t1_empty_fill",   b0.fill === 3'd0,    b0.fill,    0);
    chk("t1_empty_aempty", b0.aempty === 1'b1,  b0.aempty,  1);
    chk("t1_empty_valid",  b0.o_valid === 1'b0, b0.o_valid, 0);

    // simultaneous push/pop at fill=1
    b0.i_valid = 1'b1; b0.i_data = 8'h31;
    tick();
    chk("t4_f1_fill", b0.fill === 3'd1,     b0.fill,   1);
    chk("t4_f1_head", b0.o_data === 8'h31,  b0.o_data, 8'h31);
    b0.i_data = 8'h32; b0.o_ready = 1'b1;
    tick();
    b0.i_valid = 1'b0; b0.o_ready = 1'b0;
    chk("t4_f1_fill_after", b0.fill === 3'd1,    b0.fill,    1);
    chk("t4_f1_valid",      b0.o_valid === 1'b1, b0.o_valid, 1);
    chk("t4_f1_new_head",   b0.o_data === 8'h32, b0.o_data,  8'h32);
    b0.o_ready = 1'b1;
    tick();
    b0.o_ready = 1'b0;
    chk("t4_f1_drained", b0.fill === 3'd0, b0.fill, 0);

    // simultaneous push/pop at full: only the pop happens
    for (int i = 0; i < 4; i++) begin
      b0.i_valid = 1'b1; b0.i_data = 8'(8'h40 + i);
      tick();
    end
    chk("t4_full_fill",    b0.fill === 3'd4,    b0.fill,    4);
    chk("t4_full_i_ready", b0.i_ready === 1'b0, b0.i_ready, 0);
    b0.i_data = 8'h44; b0.o_ready = 1'b1;
    chk("t4_full_head", b0.o_data === 8'h40, b0.o_data, 8'h40);
    tick();
    b0.i_valid = 1'b0;
    chk("t4_full_fill_after", b0.fill === 3'd3,    b0.fill,    3);
    chk("t4_full_i_ready_up", b0.i_ready === 1'b1, b0.i_ready, 1);
    for (int i = 1; i < 4; i++) begin
      chk("t4_full_drain", b0.o_data === 8'(8'h40 + i), b0.o_data, 8'h40 + i);
      tick();
    end
    b0.o_ready = 1'b0;
    chk("t4_full_no_extra", b0.o_valid === 1'b0, b0.o_valid, 0);
    chk("t4_full_empty",    b0.fill === 3'd0,    b0.fill,    0);

    // flush at fill=3 with a concurrent push
    for (int i = 0; i < 3; i++) begin
      b0.i_valid = 1'b1; b0.i_data = 8'(8'h50 + i);
      tick();
    end
    chk("t5_pre_fill", b0.fill === 3'd3, b0.fill, 3);
    flush0 = 1'b1; b0.i_data = 8'h5F;
    tick();
    flush0 = 1'b0; b0.i_valid = 1'b0;
    chk("t5_fill",    b0.fill === 3'd0,    b0.fill,    0);
    chk("t5_o_valid", b0.o_valid === 1'b0, b0.o_valid, 0);
    chk("t5_i_ready", b0.i_ready === 1'b1, b0.i_ready, 1);
    chk("t5_aempty",  b0.aempty === 1'b1,  b0.aempty,  1);
    tick();
    chk("t5_no_ghost", b0.o_valid === 1'b0, b0.o_valid, 0);
    b0.i_valid = 1'b1; b0.i_data = 8'h60;
    tick();
    b0.i_valid = 1'b0;
    chk("t5_new_head", b0.o_data === 8'h60, b0.o_data, 8'h60);
    chk("t5_new_fill", b0.fill === 3'd1,    b0.fill,   1);
    b0.o_ready = 1'b1;
    tick();
    b0.o_ready = 1'b0;

    // registered output: latency 2, capacity 5, back-to-back drain
    b1.i_valid = 1'b1; b1.i_data = 8'h5A;
    tick();
    b1.i_valid = 1'b0;
    chk("t2_n1_o_valid", b1.o_valid === 1'b0, b1.o_valid, 0);
    chk("t2_n1_fill",    b1.fill === 3'd1,    b1.fill,    1);
    tick();
    chk("t2_n2_o_valid", b1.o_valid === 1'b1,  b1.o_valid, 1);
    chk("t2_n2_o_data",  b1.o_data === 8'h5A,  b1.o_data,  8'h5A);
    for (int i = 0; i < 4; i++) begin
      b1.i_valid = 1'b1; b1.i_data = 8'(8'hB0 + i);
      tick();
    end
    chk("t2_cap_fill",    b1.fill === 3'd5,    b1.fill,    5);
    chk("t2_cap_i_ready", b1.i_ready === 1'b0, b1.i_ready, 0);
    chk("t2_cap_afull",   b1.afull === 1'b1,   b1.afull,   1);
    b1.i_data = 8'hEE;
    tick();
    b1.i_valid = 1'b0;
    chk("t2_refused_fill", b1.fill === 3'd5,    b1.fill,   5);
    chk("t2_head_held",    b1.o_data === 8'h5A, b1.o_data, 8'h5A);
    exp2[0] = 8'h5A; exp2[1] = 8'hB0; exp2[2] = 8'hB1; exp2[3] = 8'hB2; exp2[4] = 8'hB3;
    b1.o_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_b2b_valid", b1.o_valid === 1'b1,   b1.o_valid, 1);
      chk("t2_b2b_data",  b1.o_data === exp2[i], b1.o_data,  exp2[i]);
      tick();
    end
    b1.o_ready = 1'b0;
    chk("t2_drained_fill",  b1.fill === 3'd0,    b1.fill,    0);
    chk("t2_drained_valid", b1.o_valid === 1'b0, b1.o_valid, 0);

    // registered output at full: push refused during pop
    for (int i = 0; i < 5; i++) begin
      b1.i_valid = 1'b1; b1.i_data = 8'(8'hC0 + i);
      tick();
    end
    chk("t4r_full_fill", b1.fill === 3'd5, b1.fill, 5);
    b1.i_data = 8'hC5; b1.o_ready = 1'b1;
    tick();
    b1.i_valid = 1'b0;
    chk("t4r_fill_after", b1.fill === 3'd4,    b1.fill,    4);
    chk("t4r_i_ready",    b1.i_ready === 1'b1, b1.i_ready, 1);
    for (int i = 1; i < 5; i++) begin
      chk("t4r_drain_valid", b1.o_valid === 1'b1,         b1.o_valid, 1);
      chk("t4r_drain_data",  b1.o_data === 8'(8'hC0 + i), b1.o_data,  8'hC0 + i);
      tick();
    end
    b1.o_ready = 1'b0;
    chk("t4r_no_extra", b1.o_valid === 1'b0, b1.o_valid, 0);

    // random valid/ready, 64 incrementing words through each instance
    wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0; cyc = 0;
    while ((rd0 < 64 || rd1 < 64) && cyc < 3000) begin
      chk("rnd0_fill", 32'(b0.fill) === 32'(wr0 - rd0), b0.fill, wr0 - rd0);
      chk("rnd0_cap",  b0.fill <= 3'd4, b0.fill, 4);
      chk("rnd1_fill", 32'(b1.fill) === 32'(wr1 - rd1), b1.fill, wr1 - rd1);
      chk("rnd1_cap",  b1.fill <= 3'd5, b1.fill, 5);
      b0.i_valid = (wr0 < 64) && ($urandom_range(0, 1) == 1);
      b0.i_data  = 8'(wr0);
      b0.o_ready = ($urandom_range(0, 1) == 1);
      b1.i_valid = (wr1 < 64) && ($urandom_range(0, 1) == 1);
      b1.i_data  = 8'(wr1);
      b1.o_ready = ($urandom_range(0, 1) == 1);
      p0 = b0.i_valid & b0.i_ready;
      q0 = b0.o_valid & b0.o_ready;
      p1 = b1.i_valid & b1.i_ready;
      q1 = b1.o_valid & b1.o_ready;
      if (q0) chk("rnd0_data", b0.o_data === 8'(rd0), b0.o_data, 8'(rd0));
      if (q1) chk("rnd1_data", b1.o_data === 8'(rd1), b1.o_data, 8'(rd1));
      tick();
      if (p0) wr0++;
      if (q0) rd0++;
      if (p1) wr1++;
      if (q1) rd1++;
      cyc++;
    end
    b0.i_valid = 1'b0; b0.o_ready = 1'b0;
    b1.i_valid = 1'b0; b1.o_ready = 1'b0;
    chk("rnd0_count", rd0 == 64, rd0, 64);
    chk("rnd1_count", rd1 == 64, rd1, 64);

    // asynchronous reset mid-stream at fill=2
    b0.i_valid = 1'b1; b0.i_data = 8'h70;
    tick();
    b0.i_data = 8'h71;
    tick();
    b0.i_valid = 1'b0;
    chk("t6_pre_fill", b0.fill === 3'd2, b0.fill, 2);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_async_o_valid", b0.o_valid === 1'b0, b0.o_valid, 0);
    chk("t6_async_fill",    b0.fill === 3'd0,    b0.fill,    0);
    chk("t6_async_i_ready", b0.i_ready === 1'b1, b0.i_ready, 1);
    #2 aresetn = 1'b1;
    b0.i_valid = 1'b1; b0.i_data = 8'h11;
    b1.i_valid = 1'b1; b1.i_data = 8'h22;
    tick();
    b0.i_valid = 1'b0; b1.i_valid = 1'b0;
    chk("t6_first_valid", b0.o_valid === 1'b1,  b0.o_valid, 1);
    chk("t6_first_data",  b0.o_data === 8'h11,  b0.o_data,  8'h11);
    chk("t6_r_lat1",      b1.o_valid === 1'b0,  b1.o_valid, 0);
    tick();
    chk("t6_r_lat2_valid", b1.o_valid === 1'b1, b1.o_valid, 1);
    chk("t6_r_lat2_data",  b1.o_data === 8'h22, b1.o_data,  8'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
